// File: rtl/flappy_pkg.sv
// Key codes and decoder state encoding shared by the input path of the game.
// Latency: none (declarations only).
// Backpressure: none.
package flappy_pkg;

    localparam logic [7:0] KEY_SPACE    = 8'd32;
    localparam logic [7:0] KEY_W        = 8'h77;
    localparam logic [7:0] KEY_P        = 8'h70;
    localparam logic [7:0] KEY_Q        = 8'h71;
    localparam logic [7:0] KEY_ESC      = 8'h1B;
    localparam logic [7:0] KEY_LBRACK   = 8'h5B;
    localparam logic [7:0] KEY_UP_FINAL = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ESC  = 2'd1,
        ST_CSI  = 2'd2
    } state_t;

    // Saturating increment for the drop counter (sticks at 8'hFF).
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/input_decoder_if.sv
// Byte stream from io into the decoder and decoded game commands out of it.
// Latency: none (wiring only).
// Backpressure: none; the io stage pushes one byte per cycle when inp_valid is high.
// Ports: inp/inp_valid (io -> decoder); flap, flap_held, paused, quit, drop_cnt (decoder -> controller).
interface input_decoder_if;
    logic [7:0] inp;
    logic       inp_valid;
    logic       flap;
    logic       flap_held;
    logic       paused;
    logic       quit;
    logic [7:0] drop_cnt;

    // master: the byte source (io stage / bench); slave: the decoder
    modport master (
        output inp, inp_valid,
        input  flap, flap_held, paused, quit, drop_cnt
    );
    modport slave (
        input  inp, inp_valid,
        output flap, flap_held, paused, quit, drop_cnt
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a level held for HOLD_LEN cycles; re-trigger reloads.
// Latency: out rises the cycle after the edge that samples trig.
// Backpressure: none; en=0 freezes the counter in place.
// Ports: clk, rst (sync, active-high), en (advance/load enable), trig (load pulse), out (held level).
module pulse_stretcher #(
    parameter int HOLD_LEN = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic trig,
    output logic out
);
    localparam int              CW   = $clog2(HOLD_LEN + 1);
    localparam logic [CW-1:0]   LOAD = CW'(HOLD_LEN);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en) begin
            if (trig) begin
                cnt_q <= LOAD;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign out = (cnt_q != '0);

endmodule

// File: rtl/input_decoder.sv
// Decodes raw stdin bytes (incl. ESC [ A arrow sequences) into flap/pause/quit commands.
// Latency: all outputs registered; a byte sampled at edge N shows on outputs after edge N.
// Backpressure: none; every valid byte is consumed the cycle it is presented.
// Ports: clk, rst (sync, active-high), bus (input_decoder_if.slave: inp, inp_valid in; flap,
//        flap_held, paused, quit, drop_cnt out).
module input_decoder #(
    parameter int HOLD_LEN    = 5,
    parameter int ESC_TIMEOUT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input_decoder_if.slave   bus
);
    import flappy_pkg::*;

    localparam int            TW         = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(ESC_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          paused_q, paused_d;
    logic          quit_q, quit_d;
    logic          flap_q, flap_d;
    logic [7:0]    drop_q, drop_d;
    logic          want_flap;
    logic          do_drop;
    logic          dispatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            paused_q <= 1'b0;
            quit_q   <= 1'b0;
            flap_q   <= 1'b0;
            drop_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            paused_q <= paused_d;
            quit_q   <= quit_d;
            flap_q   <= flap_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        paused_d  = paused_q;
        quit_d    = quit_q;
        drop_d    = drop_q;
        want_flap = 1'b0;
        do_drop   = 1'b0;
        dispatch  = 1'b0;

        // Once quit is set the decoder is inert: nothing below is evaluated.
        if (!quit_q) begin
            case (state_q)
                ST_IDLE: begin
                    dispatch = bus.inp_valid;
                end
                ST_ESC: begin
                    if (bus.inp_valid) begin
                        if (bus.inp == KEY_LBRACK) begin
                            state_d = ST_CSI;
                            timer_d = '0;
                        end else begin
                            // Not a CSI introducer: handle the byte as if ESC never came.
                            state_d  = ST_IDLE;
                            dispatch = 1'b1;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        // A lone ESC key press means quit.
                        quit_d  = 1'b1;
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_CSI: begin
                    if (bus.inp_valid) begin
                        state_d = ST_IDLE;
                        if (bus.inp == KEY_UP_FINAL) begin
                            want_flap = 1'b1;
                        end else begin
                            do_drop = 1'b1;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        do_drop = 1'b1;
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase

            if (dispatch) begin
                case (bus.inp)
                    KEY_SPACE, KEY_W: want_flap = 1'b1;
                    KEY_P:            paused_d  = ~paused_q;
                    KEY_Q:            quit_d    = 1'b1;
                    KEY_ESC: begin
                        // Overrides the return-to-IDLE above when ESC follows ESC.
                        state_d = ST_ESC;
                        timer_d = '0;
                    end
                    default:          do_drop   = 1'b1;
                endcase
            end

            if (do_drop) begin
                drop_d = sat_inc8(drop_q);
            end
        end

        flap_d = want_flap && !paused_q && !quit_q;
    end

    pulse_stretcher #(
        .HOLD_LEN (HOLD_LEN)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .en   (~quit_q),
        .trig (flap_d),
        .out  (bus.flap_held)
    );

    assign bus.flap     = flap_q;
    assign bus.paused   = paused_q;
    assign bus.quit     = quit_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_input_decoder.sv
module tb_input_decoder;
    import flappy_pkg::*;

    localparam int HOLD_LEN    = 5;
    localparam int ESC_TIMEOUT = 3;

    logic clk;
    logic rst;
    input_decoder_if bus();

    input_decoder #(
        .HOLD_LEN    (HOLD_LEN),
        .ESC_TIMEOUT (ESC_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_seq: how much of an arrow sequence has been seen (0 none, 1 ESC, 2 ESC '[')
    // m_idle: idle cycles since the sequence began waiting
    int m_seq, m_idle, m_hold, m_drop;
    bit m_flap, m_paused, m_quit;

    task automatic m_dispatch(input logic [7:0] b, inout bit f);
        if (b == KEY_SPACE || b == KEY_W) f = 1'b1;
        else if (b == KEY_P) m_paused = !m_paused;
        else if (b == KEY_Q) m_quit = 1'b1;
        else if (b == KEY_ESC) begin m_seq = 1; m_idle = 0; end
        else if (m_drop < 255) m_drop++;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_seq = 0; m_idle = 0; m_hold = 0; m_drop = 0;
            m_flap = 0; m_paused = 0; m_quit = 0;
        end else if (m_quit) begin
            m_flap = 0;
        end else begin
            bit f;
            f = 1'b0;
            if (bus.inp_valid) begin
                m_idle = 0;
                if (m_seq == 2) begin
                    m_seq = 0;
                    if (bus.inp == "A") f = 1'b1;
                    else if (m_drop < 255) m_drop++;
                end else if (m_seq == 1 && bus.inp == "[") begin
                    m_seq = 2;
                end else begin
                    m_seq = 0;
                    m_dispatch(bus.inp, f);
                end
            end else if (m_seq != 0) begin
                m_idle++;
                if (m_idle == ESC_TIMEOUT) begin
                    if (m_seq == 1) m_quit = 1'b1;
                    else if (m_drop < 255) m_drop++;
                    m_seq = 0;
                    m_idle = 0;
                end
            end
            m_flap = f && !m_paused;
            if (m_flap) m_hold = HOLD_LEN;
            else if (m_hold > 0) m_hold--;
        end
    end

    always @(negedge clk) begin
        check("cyc_flap",      32'(bus.flap),      32'(m_flap));
        check("cyc_flap_held", 32'(bus.flap_held), 32'(m_hold != 0));
        check("cyc_paused",    32'(bus.paused),    32'(m_paused));
        check("cyc_quit",      32'(bus.quit),      32'(m_quit));
        check("cyc_drop_cnt",  32'(bus.drop_cnt),  m_drop);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [7:0] b);
        bus.inp_valid = v;
        bus.inp       = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'hFF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    int nh, nf;

    initial begin
        rst = 1'b1;
        bus.inp_valid = 1'b0;
        bus.inp = 8'h00;
        step(1'b0, 8'h00);
        step(1'b1, 8'h00);
        check("rst_flap",      32'(bus.flap),      0);
        check("rst_flap_held", 32'(bus.flap_held), 0);
        check("rst_paused",    32'(bus.paused),    0);
        check("rst_quit",      32'(bus.quit),      0);
        check("rst_drop_cnt",  32'(bus.drop_cnt),  0);
        rst = 1'b0;

        // space: one-cycle flap, held level for HOLD_LEN cycles
        step(1'b1, KEY_SPACE);
        check("space_flap", 32'(bus.flap), 1);
        nh = int'(bus.flap_held);
        step(1'b0, 8'h00);
        check("space_flap_1cyc", 32'(bus.flap), 0);
        nh += int'(bus.flap_held);
        for (int i = 0; i < 6; i++) begin step(1'b0, 8'hFF); nh += int'(bus.flap_held); end
        check("space_held_len", nh, 5);

        // retrigger while held
        step(1'b1, KEY_SPACE);
        idle(2);
        step(1'b1, KEY_W);
        nh = int'(bus.flap_held);
        for (int i = 0; i < 7; i++) begin step(1'b0, 8'hFF); nh += int'(bus.flap_held); end
        check("retrig_held_len", nh, 5);

        // up-arrow back-to-back
        step(1'b1, KEY_ESC);
        check("up_esc_noflap", 32'(bus.flap), 0);
        step(1'b1, KEY_LBRACK);
        check("up_brk_noflap", 32'(bus.flap), 0);
        step(1'b1, KEY_UP_FINAL);
        check("up_flap", 32'(bus.flap), 1);
        check("up_drop", 32'(bus.drop_cnt), 0);
        idle(6);

        // ESC then space: space re-dispatched, no drop
        step(1'b1, KEY_ESC);
        step(1'b1, KEY_SPACE);
        check("esc_space_flap", 32'(bus.flap), 1);
        check("esc_space_drop", 32'(bus.drop_cnt), 0);
        // ESC ESC [ A: second ESC restarts the sequence
        step(1'b1, KEY_ESC);
        step(1'b1, KEY_ESC);
        step(1'b1, KEY_LBRACK);
        step(1'b1, KEY_UP_FINAL);
        check("esc_esc_up_flap", 32'(bus.flap), 1);
        idle(6);

        // pause suppresses flap
        nf = 0;
        step(1'b1, KEY_P);
        check("pause_on", 32'(bus.paused), 1);
        step(1'b1, KEY_SPACE);
        check("paused_noflap", 32'(bus.flap), 0);
        nf += int'(bus.flap);
        step(1'b1, KEY_P);
        check("pause_off", 32'(bus.paused), 0);
        step(1'b1, KEY_SPACE);
        nf += int'(bus.flap);
        check("pause_flap_count", nf, 1);
        idle(6);

        // bad CSI final byte
        step(1'b1, KEY_ESC);
        step(1'b1, KEY_LBRACK);
        step(1'b1, 8'h5A);
        check("csi_z_drop", 32'(bus.drop_cnt), 1);
        step(1'b1, KEY_SPACE);
        check("csi_z_back_idle", 32'(bus.flap), 1);
        idle(6);

        // CSI timeout after exactly ESC_TIMEOUT idle cycles
        step(1'b1, KEY_ESC);
        step(1'b1, KEY_LBRACK);
        idle(2);
        check("csi_to_early", 32'(bus.drop_cnt), 1);
        idle(1);
        check("csi_to_drop", 32'(bus.drop_cnt), 2);

        // saturation
        for (int i = 0; i < 300; i++) step(1'b1, 8'h78);
        check("drop_sat", 32'(bus.drop_cnt), 255);

        // rst mid-sequence beats the same-cycle byte
        do_reset();
        step(1'b1, KEY_ESC);
        step(1'b1, KEY_LBRACK);
        rst = 1'b1;
        step(1'b1, KEY_UP_FINAL);
        rst = 1'b0;
        step(1'b1, KEY_UP_FINAL);
        check("rst_mid_noflap", 32'(bus.flap), 0);
        check("rst_mid_drop", 32'(bus.drop_cnt), 1);
        idle(2);

        // ESC then q re-dispatched as quit
        do_reset();
        step(1'b1, KEY_ESC);
        step(1'b1, KEY_Q);
        check("esc_q_quit", 32'(bus.quit), 1);

        // bare ESC timeout = quit; everything freezes afterwards
        do_reset();
        step(1'b1, KEY_SPACE);
        step(1'b1, KEY_ESC);
        idle(2);
        check("esc_to_early", 32'(bus.quit), 0);
        idle(1);
        check("esc_to_quit", 32'(bus.quit), 1);
        check("quit_held_frozen", 32'(bus.flap_held), 1);
        step(1'b1, KEY_SPACE);
        check("quit_noflap", 32'(bus.flap), 0);
        step(1'b1, KEY_P);
        step(1'b1, 8'h78);
        idle(10);
        check("quit_paused_frozen", 32'(bus.paused), 0);
        check("quit_drop_frozen", 32'(bus.drop_cnt), 0);
        check("quit_held_still", 32'(bus.flap_held), 1);
        check("quit_sticky", 32'(bus.quit), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
